// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and default width for the execute-stage multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multdiv_iter.sv
// One shift-add (mul) or restoring-subtract (div) step per cycle over WIDTH cycles; acc_nxt is the post-step value.
// Divide datapath exists only when MULTDIV_DIV_EN is defined; otherwise multiply only.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
`ifdef MULTDIV_DIV_EN
  input  logic               div_mode,
`endif
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));

`ifdef MULTDIV_DIV_EN
  logic           div_q, div_d;
  logic [WIDTH:0] shifted, diff;

  assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff    = shifted - {1'b0, opnd_q};

  always_comb begin
    if (!div_q)
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    else if (diff[WIDTH])
      acc_nxt = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end
`else
  assign acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
`ifdef MULTDIV_DIV_EN
    div_d  = div_q;
`endif
    if (load) begin
      cnt_d  = '0;
`ifdef MULTDIV_DIV_EN
      div_d  = div_mode;
      acc_d  = {{WIDTH{1'b0}}, div_mode ? a_mag : b_mag};
      opnd_d = div_mode ? b_mag : a_mag;
`else
      acc_d  = {{WIDTH{1'b0}}, b_mag};
      opnd_d = a_mag;
`endif
    end else if (step) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef MULTDIV_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
`ifdef MULTDIV_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/execute_multdiv.sv
// Iterative signed mul/div: stall high start..WIDTH, result_valid strobe at WIDTH+1; flush aborts.
// MULTDIV_DIV_EN enables divide; without it a div completes next cycle with result 0 and exception set.
module execute_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             exception
);

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               is_mul_op, is_div_op, start, load, step, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_nxt, prod_s;
  logic               unused_instr_bits;

  assign is_mul_op = (instruction[31:27] == OP_ALU) && (instruction[6:2] == ALUOP_MUL);
  assign is_div_op = (instruction[31:27] == OP_ALU) && (instruction[6:2] == ALUOP_DIV);
  assign unused_instr_bits = ^{instruction[26:7], instruction[1:0]};

  assign start = (state_q == IDLE) && (is_mul_op || is_div_op) && !flush;
  assign stall = start || (state_q == BUSY);
  assign result_valid = (state_q == DONE) && !flush;
  assign result    = result_q;
  assign exception = exc_q;

  assign a_mag  = dataA[WIDTH-1] ? -dataA : dataA;
  assign b_mag  = dataB[WIDTH-1] ? -dataB : dataB;
  assign prod_s = sign_q ? -acc_nxt : acc_nxt;

`ifdef MULTDIV_DIV_EN
  logic div_q, div_d, dz_q, dz_d, dov_q, dov_d;
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    load     = 1'b0;
    step     = 1'b0;
`ifdef MULTDIV_DIV_EN
    div_d    = div_q;
    dz_d     = dz_q;
    dov_d    = dov_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = dataA[WIDTH-1] ^ dataB[WIDTH-1];
`ifdef MULTDIV_DIV_EN
          state_d = BUSY;
          load    = 1'b1;
          div_d   = is_div_op;
          dz_d    = (dataB == '0);
          dov_d   = (dataA == {1'b1, {(WIDTH-1){1'b0}}}) && (&dataB);
`else
          if (is_div_op) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            state_d = BUSY;
            load    = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            state_d  = DONE;
            result_d = prod_s[WIDTH-1:0];
            // overflow when the top WIDTH+1 bits are not a pure sign extension
            exc_d    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
`ifdef MULTDIV_DIV_EN
            if (div_q) begin
              result_d = dz_q ? '0 : (sign_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0]);
              exc_d    = dz_q || dov_q;
            end
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      dov_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_DIV_EN
      div_q    <= div_d;
      dz_q     <= dz_d;
      dov_q    <= dov_d;
`endif
    end
  end

  multdiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
`ifdef MULTDIV_DIV_EN
    .div_mode (is_div_op),
`endif
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_nxt  (acc_nxt),
    .last     (last)
  );

endmodule

// File: tb/tb_execute_multdiv.sv
// Directed table-driven bench for execute_multdiv plus flush/reset/back-to-back sequences.
// Divide expectations follow MULTDIV_DIV_EN.
module tb_execute_multdiv;

  localparam logic [31:0] MUL_I  = 32'h0000_0018;
  localparam logic [31:0] DIV_I  = 32'h0000_001C;
  localparam logic [31:0] NOP_I  = 32'h0000_0000;
  localparam logic [31:0] ADDI_I = 32'h2800_0018;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] instruction, dataA, dataB, result;
  logic        stall, result_valid, exception;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  execute_multdiv #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .instruction  (instruction),
    .dataA        (dataA),
    .dataB        (dataB),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .exception    (exception)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic exc);
    vec_t v;
    v.instr = instr; v.a = a; v.b = b; v.res = res; v.exc = exc; v.lat = 33;
    if (instr == DIV_I && !DIV_EN) begin
      v.res = 32'h0; v.exc = 1'b1; v.lat = 1;
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called right after an edge: presents the op in cycle 0 and tracks it to its strobe.
  task automatic run_op(input vec_t v, input string name);
    int stall_cnt = 0;
    int vcyc = -1;
    logic [31:0] held;
    instruction = v.instr; dataA = v.a; dataB = v.b;
    for (int c = 0; c < 100 && vcyc < 0; c++) begin
      @(negedge clk);
      if (result_valid) begin
        vcyc = c;
        chk({name, "_result"}, result, v.res);
        chk({name, "_exception"}, 32'(exception), 32'(v.exc));
        chk({name, "_stall_in_done"}, 32'(stall), 32'h0);
      end else if (stall) begin
        stall_cnt++;
      end
      next_cycle();
    end
    chk({name, "_latency"}, 32'(vcyc), 32'(v.lat));
    chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(v.lat));
    held = v.res;
    instruction = NOP_I;
    @(negedge clk);
    chk({name, "_valid_after"}, 32'(result_valid), 32'h0);
    chk({name, "_result_held"}, result, held);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, vcount;

    vecs[0]  = mk(MUL_I, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    vecs[1]  = mk(MUL_I, 32'h4000_0000, 32'd4,         32'h0000_0000, 1'b1);
    vecs[2]  = mk(DIV_I, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
    vecs[3]  = mk(DIV_I, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
    vecs[4]  = mk(MUL_I, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0);
    vecs[5]  = mk(MUL_I, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    vecs[6]  = mk(MUL_I, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    vecs[7]  = mk(MUL_I, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    vecs[8]  = mk(DIV_I, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    vecs[9]  = mk(DIV_I, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    vecs[10] = mk(DIV_I, 32'd7,          32'd100,       32'h0000_0000, 1'b0);
    vecs[11] = mk(DIV_I, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    vecs[12] = mk(MUL_I, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1);
    vecs[13] = mk(MUL_I, 32'd12345,      32'd0,         32'h0000_0000, 1'b0);
    vecs[14] = mk(DIV_I, 32'd0,          32'd5,         32'h0000_0000, 1'b0);
    vecs[15] = mk(DIV_I, 32'd1000,       32'd3,         32'd333,       1'b0);

    rst = 1'b1; flush = 1'b0; instruction = NOP_I; dataA = '0; dataB = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_valid", 32'(result_valid), 32'h0);
    chk("reset_exception", 32'(exception), 32'h0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // flush in cycle 10 of a mul
    vcount = 0;
    instruction = MUL_I; dataA = 32'd11; dataB = 32'd13;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (result_valid) vcount++;
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    if (result_valid) vcount++;
    next_cycle();
    flush = 1'b0; instruction = NOP_I;
    @(negedge clk);
    chk("flush_stall_after", 32'(stall), 32'h0);
    for (int c = 0; c < 40; c++) begin
      if (result_valid) vcount++;
      next_cycle();
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(vcount), 32'h0);
    next_cycle();
    run_op(mk(MUL_I, 32'd9, 32'd9, 32'd81, 1'b0), "after_flush");

    // flush coinciding with a start
    vcount = 0;
    instruction = MUL_I; dataA = 32'd2; dataB = 32'd2; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 32'(stall), 32'h0);
    next_cycle();
    flush = 1'b0; instruction = NOP_I;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid || stall) vcount++;
      next_cycle();
    end
    chk("flush_start_idle", 32'(vcount), 32'h0);

    // reset in cycle 5 of a div
    vcount = 0;
    instruction = DIV_I; dataA = 32'd1000; dataB = 32'd3;
    for (int c = 0; c < 5; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; instruction = NOP_I;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_exception", 32'(exception), 32'h0);
    chk("rst_mid_valid", 32'(result_valid), 32'h0);
    for (int c = 0; c < 40; c++) begin
      if (result_valid) vcount++;
      next_cycle();
      @(negedge clk);
    end
    chk("rst_mid_no_valid", 32'(vcount), 32'h0);
    next_cycle();

    // non-multdiv opcode carrying a mul ALU-op field
    instruction = ADDI_I;
    @(negedge clk);
    chk("nonmd_stall", 32'(stall), 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("nonmd_valid", 32'(result_valid), 32'h0);
    next_cycle();

    // back-to-back multiplies
    first = -1; second = -1;
    instruction = MUL_I; dataA = 32'd3; dataB = 32'd4;
    for (int c = 0; c < 120 && second < 0; c++) begin
      @(negedge clk);
      if (first >= 0 && c == first + 1) chk("b2b_second_start_stall", 32'(stall), 32'h1);
      if (result_valid) begin
        if (first < 0) begin
          first = c;
          chk("b2b_first_result", result, 32'd12);
        end else begin
          second = c;
          chk("b2b_second_result", result, 32'd30);
        end
      end
      next_cycle();
      if (c == first) begin
        dataA = 32'd5; dataB = 32'd6;
      end
    end
    instruction = NOP_I;
    chk("b2b_first_latency", 32'(first), 32'd33);
    chk("b2b_gap", 32'(second - first), 32'd34);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_multdiv.md
# execute_multdiv

Iterative signed multiply/divide unit in the execute stage. Consumes `instruction`, `dataA` and `dataB` straight from the decode-to-execute pipeline register. Raises `stall` while it works; the hazard logic drives that pipeline register's `enable` low for as long as `stall` is high, so the register holds the operands. After the operation it presents a 32-bit result and an exception flag for one cycle, for the execute-to-memory register to capture.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `flush` in 1 — abort the current operation (later-stage redirect/exception).
- `instruction` in 32 — instruction held in the execute stage.
- `dataA` in 32 — rs operand (multiplicand / dividend).
- `dataB` in 32 — rt operand (multiplier / divisor).
- `stall` out 1 — hold upstream stages.
- `result` out 32 — product low word or quotient.
- `result_valid` out 1 — one-cycle strobe; `result` and `exception` are valid.
- `exception` out 1 — multiply overflow or divide by zero; valid with `result_valid`.

## Operation
- Decode: the instruction is a multdiv op when opcode `instruction[31:27]==5'b00000` and ALU op `instruction[6:2]` is `5'b00110` (mul) or `5'b00111` (div). `start = (state==IDLE) & is_multdiv & ~flush`.
- FSM states:
  - IDLE -> BUSY on `start`. Latch operand magnitudes, result sign (`dataA[31]^dataB[31]`) and op type; clear the counter.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. The counter counts 0..WIDTH-1. BUSY -> DONE when the counter reaches WIDTH-1.
  - DONE -> IDLE unconditionally. `result_valid=1` in this cycle only. Start is ignored in DONE because the same instruction is still present and leaves the pipeline register at this edge.
- `stall = start | (state==BUSY)`. It is combinational so the start cycle is covered.
- Multiply:
  - 64-bit unsigned magnitude product, negated if the result sign is set. `result` = low 32 bits.
  - `exception` = 1 when the upper 33 bits of the signed product are not all equal.
- Divide:
  - Unsigned restoring division on the magnitudes. The quotient is negated if the result sign is set, which truncates toward zero. The remainder is discarded.
  - Divisor 0: `result=0`, `exception=1`; iteration still runs the full length.
  - -2^31 / -1: `result=32'h80000000`, `exception=1`.
- `flush`:
  - In BUSY or DONE, the next state is IDLE and no `result_valid` is produced.
  - `flush` together with a valid start: flush wins; no start, `stall=0`.
- `rst` in any state: IDLE, counter 0.
- Non-multdiv instructions: outputs idle; the ALU path handles them.

## Timing
- Reset values: `stall=0`, `result=0`, `result_valid=0`, `exception=0`, state IDLE.
- Instruction first present in cycle 0 (start):
  - `stall` high cycles 0..WIDTH (33 cycles for WIDTH=32).
  - `result_valid` high in cycle WIDTH+1 only.
  - `stall` low in that cycle.
- `result`/`exception` are registered and hold their last value until the next DONE. They are qualified only by `result_valid`.
- Back-to-back multdiv ops: the second one starts in the cycle after DONE. There is no idle gap beyond the DONE cycle.

## Configuration
- `MULTDIV_DIV_EN` defined: full divide support as above.
- Without `MULTDIV_DIV_EN`:
  - Divider logic is not built; the unit implements multiply only.
  - A div op goes IDLE -> DONE directly, with `stall` high in the start cycle only.
  - In DONE, `result=0`, `exception=1`.

## Structure
- Shared package `multdiv_pkg`:
  - opcode/ALU-op constants (`OP_ALU`, `ALUOP_MUL`, `ALUOP_DIV`);
  - state enum (IDLE, BUSY, DONE);
  - `WIDTH` default.
- One sub-module, `multdiv_iter`: the per-cycle shift/add/subtract datapath (accumulator, operand shift registers, counter).
- The top level holds the FSM, decode, sign handling and exception logic.

## Test plan
- mul 7 × -3 in cycle 0 -> `stall` high cycles 0..32; cycle 33: `result=32'hFFFFFFEB` (-21), `exception=0`, `result_valid=1`.
- mul `32'h40000000` × 4 -> `result=0`, `exception=1` (overflow).
- div -100 / 7 -> `result=-14` (`32'hFFFFFFF2`), `exception=0`; div 5 / 0 -> `result=0`, `exception=1`, full 33-cycle stall.
- mul started, `flush` at cycle 10 -> cycle 11: `stall=0`, IDLE; no `result_valid` ever; the next mul produces a correct result.
- `rst` asserted at cycle 5 of a div -> next cycle: all outputs 0, IDLE; an add (ALU op 00000) in the stage -> `stall=0`, no `result_valid`.
- mul followed immediately by mul -> second start in the cycle after the first DONE; two `result_valid` pulses exactly 34 cycles apart.
